serial_parity_checker: RTL and testbench

SERIAL_PARITY_CHECKER -- requirements
Module: serial_parity_checker

---
 rtl/serial_parity_checker.sv | 113 +++++++++++
 tb/tb_serial_parity_checker.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_parity_checker.sv
// Serial parity checker: accumulates FRAME_LEN data bits, then compares against a trailing
// parity bit. Reports per-frame result and a saturating count of failed frames.
module serial_parity_checker #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned EVEN      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic       i_bit,
  output logic       o_ready,
  output logic       o_done,
  output logic       o_ok,
  output logic [7:0] o_count,
  output logic [7:0] o_err_cnt
);

  localparam logic [7:0] FrameLen = 8'(FRAME_LEN);
  // Total XOR of data plus parity that counts as a pass.
  localparam logic       TargetXor = (EVEN == 0);

  typedef enum logic [1:0] {StIdle, StData, StParity, StDone} state_e;

  state_e     state_q, state_d;
  logic       acc_q, acc_d;
  logic       ok_q, ok_d;
  logic [7:0] count_q, count_d;
  logic [7:0] err_q, err_d;
  logic       accept;

  assign accept = i_valid & o_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = (FRAME_LEN == 1) ? StParity : StData;
      end
      StData: begin
        if (accept && (count_q + 8'd1 == FrameLen)) state_d = StParity;
      end
      StParity: begin
        if (accept) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_ready = (state_q != StDone);
    o_done  = (state_q == StDone);
  end

  always_comb begin
    acc_d   = acc_q;
    ok_d    = ok_q;
    count_d = count_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          acc_d   = i_bit;
          count_d = 8'd1;
        end
      end
      StData: begin
        if (accept) begin
          acc_d   = acc_q ^ i_bit;
          count_d = count_q + 8'd1;
        end
      end
      StParity: begin
        if (accept) begin
          ok_d = ((acc_q ^ i_bit) == TargetXor);
          if (!ok_d && (err_q != 8'hFF)) err_d = err_q + 8'd1;
        end
      end
      StDone: begin
        acc_d   = 1'b0;
        count_d = 8'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= 1'b0;
      ok_q    <= 1'b0;
      count_q <= 8'd0;
      err_q   <= 8'd0;
    end else begin
      acc_q   <= acc_d;
      ok_q    <= ok_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign o_ok      = ok_q;
  assign o_count   = count_q;
  assign o_err_cnt = err_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Randomized self-checking bench for serial_parity_checker: a frame-level parity model
// (bit counting) predicts result, error count and handshake timing.
module tb_serial_parity_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid, i_bit;
  logic       o_ready, o_done, o_ok;
  logic [7:0] o_count, o_err_cnt;

  logic       v2, b2;
  logic       ready2, done2, ok2;
  logic [7:0] count2, err2;

  int checks = 0;
  int errors = 0;

  int exp_count = 0;
  int exp_err   = 0;
  logic exp_ok  = 1'b0;

  always #5 clk = ~clk;

  serial_parity_checker #(.FRAME_LEN(8), .EVEN(1)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_bit(i_bit),
    .o_ready(o_ready), .o_done(o_done), .o_ok(o_ok),
    .o_count(o_count), .o_err_cnt(o_err_cnt)
  );

  serial_parity_checker #(.FRAME_LEN(1), .EVEN(0)) dut_odd1 (
    .clk(clk), .rst(rst), .i_valid(v2), .i_bit(b2),
    .o_ready(ready2), .o_done(done2), .o_ok(ok2),
    .o_count(count2), .o_err_cnt(err2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Frame-level expectation: pass when the number of ones (data + parity) is even.
  function automatic logic even_ok(input logic [7:0] data, input logic par);
    int ones;
    ones = $countones(data) + int'(par);
    return (ones % 2) == 0;
  endfunction

  task automatic send_data_bit(input logic b, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        i_valid = 1'b0;
        i_bit   = 1'($urandom);
        cyc();
        check("gap_count_hold", 32'(o_count), 32'(exp_count));
        check("gap_no_done", 32'(o_done), 32'd0);
      end
    end
    i_valid = 1'b1;
    i_bit   = b;
    cyc();
    exp_count++;
    check("data_count", 32'(o_count), 32'(exp_count));
    check("data_ready", 32'(o_ready), 32'd1);
    check("data_ok_hold", 32'(o_ok), 32'(exp_ok));
  endtask

  task automatic run_frame(input logic [7:0] data, input logic par, input bit gaps,
                           input bit full_checks);
    for (int i = 0; i < 8; i++) begin
      if (full_checks) begin
        send_data_bit(data[i], gaps);
      end else begin
        i_valid = 1'b1;
        i_bit   = data[i];
        cyc();
        exp_count++;
      end
    end
    if (gaps) begin
      i_valid = 1'b0;
      repeat ($urandom_range(0, 2)) cyc();
    end
    i_valid = 1'b1;
    i_bit   = par;
    cyc();
    exp_ok = even_ok(data, par);
    if (!exp_ok && exp_err < 255) exp_err++;
    check("done_pulse", 32'(o_done), 32'd1);
    check("done_not_ready", 32'(o_ready), 32'd0);
    check("frame_ok", 32'(o_ok), 32'(exp_ok));
    check("err_cnt", 32'(o_err_cnt), 32'(exp_err));
    // Keep i_valid high through DONE with a bit that must not be consumed.
    i_valid = 1'b1;
    i_bit   = 1'($urandom);
    cyc();
    exp_count = 0;
    check("done_one_cycle", 32'(o_done), 32'd0);
    check("idle_ready", 32'(o_ready), 32'd1);
    check("idle_count", 32'(o_count), 32'd0);
    i_valid = 1'b0;
  endtask

  task automatic run_odd1(input logic d, input logic p, input logic exp_ok2,
                          input int exp_err2);
    v2 = 1'b1;
    b2 = d;
    cyc();
    check("odd1_count", 32'(count2), 32'd1);
    check("odd1_no_done", 32'(done2), 32'd0);
    b2 = p;
    cyc();
    check("odd1_done", 32'(done2), 32'd1);
    check("odd1_ready", 32'(ready2), 32'd0);
    check("odd1_ok", 32'(ok2), 32'(exp_ok2));
    check("odd1_err", 32'(err2), 32'(exp_err2));
    b2 = 1'($urandom);
    cyc();
    check("odd1_done_clear", 32'(done2), 32'd0);
    check("odd1_count_clear", 32'(count2), 32'd0);
    v2 = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic       p;
    int         done_pulses;

    rst     = 1'b1;
    i_valid = 1'b0;
    i_bit   = 1'b0;
    v2      = 1'b0;
    b2      = 1'b0;
    #2;
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_ok", 32'(o_ok), 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_err", 32'(o_err_cnt), 32'd0);
    #1;
    rst = 1'b0;

    // All-zero frame with even parity 0.
    run_frame(8'h00, 1'b0, 1'b0, 1'b1);

    // Reset after 5 data bits: partial frame dropped, error count untouched.
    for (int i = 0; i < 5; i++) send_data_bit(1'($urandom), 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_count", 32'(o_count), 32'd0);
    check("midrst_ready", 32'(o_ready), 32'd1);
    check("midrst_done", 32'(o_done), 32'd0);
    check("midrst_ok", 32'(o_ok), 32'd0);
    check("midrst_err", 32'(o_err_cnt), 32'd0);
    rst       = 1'b0;
    exp_count = 0;
    exp_ok    = 1'b0;
    exp_err   = 0;
    run_frame(8'b0000_1101, 1'b1, 1'b0, 1'b1);

    // Data 1,0,1,1,0,0,0,0 with good then bad parity.
    run_frame(8'b0000_1101, 1'b1, 1'b0, 1'b1);
    run_frame(8'b0000_1101, 1'b0, 1'b0, 1'b1);

    // Random frames with random valid gaps.
    for (int n = 0; n < 20; n++) begin
      d = 8'($urandom);
      p = 1'($urandom);
      run_frame(d, p, 1'b1, 1'b1);
    end

    // Back-to-back bad frames drive the error counter into saturation.
    done_pulses = 0;
    for (int n = 0; n < 260; n++) begin
      d = 8'($urandom);
      p = ~(^d);
      run_frame(d, p, 1'b0, 1'b0);
      done_pulses++;
    end
    check("sat_pulses", 32'(done_pulses), 32'd260);
    check("sat_err", 32'(o_err_cnt), 32'd255);
    cyc();
    check("sat_err_hold", 32'(o_err_cnt), 32'd255);

    // Single-bit frame, odd parity.
    run_odd1(1'b1, 1'b0, 1'b1, 0);
    run_odd1(1'b1, 1'b1, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
